// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg
//   Shared definitions for the elastic pipeline family.
//   - DEFAULT_WIDTH / DEFAULT_STAGES : defaults for the medium datapath family
//   - clog2()                        : ceiling log2, used to size the
//                                      occupancy counter
package elastic_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  // Ceiling log2 for n >= 1. Returns 0 for n == 1.
  function automatic int clog2(input int n);
    int result;
    int value;
    result = 0;
    value  = n - 1;
    while (value > 0) begin
      result = result + 1;
      value  = value >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage
//   One valid/data register of the elastic pipeline.
//   Ports:
//     clk      : rising-edge clock
//     reset    : asynchronous active-low reset (valid -> 0, data -> RESET_VAL)
//     flush    : synchronous clear of the valid bit (data holds)
//     load     : stage accepts the incoming valid/data this cycle
//     in_valid : valid bit of the upstream source
//     in_data  : data word of the upstream source
//     valid    : registered valid bit
//     data     : registered data word
module elastic_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VAL;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= in_valid;
      // Bubbles leave the data register untouched to limit toggling.
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe
//   WIDTH-bit, STAGES-deep elastic pipeline with per-stage valid/ready
//   handshake, bubble collapsing, synchronous flush and occupancy count.
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous active-low reset
//     flush     : synchronous clear of all valid bits and the occupancy count
//     in_valid  : producer has a word on in_data
//     in_data   : producer word
//     in_ready  : pipeline accepts in_data this cycle
//     out_valid : last stage holds a word (straight from a register)
//     out_data  : last-stage word (straight from a register)
//     out_ready : consumer accepts out_data this cycle
//     occupancy : number of valid stages, 0..STAGES
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               STAGES    = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES:0]   r;
  logic              in_hs;
  logic              out_hs;
  logic [OCC_W-1:0]  occ_reg;

  // Ready chain: a stage can load when it is empty or its contents move on.
  // An empty stage therefore accepts even while everything downstream stalls,
  // which is what collapses bubbles.
  always_comb begin
    r         = '0;
    r[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r[i] = !v[i] || r[i+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (gi == 0) begin : g_src_in
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_src_prev
        assign src_valid = v[gi-1];
        assign src_data  = d[gi-1];
      end

      elastic_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load     (r[gi]),
        .in_valid (src_valid),
        .in_data  (src_data),
        .valid    (v[gi]),
        .data     (d[gi])
      );
    end
  endgenerate

  assign in_ready  = r[0] && !flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Occupancy tracks handshakes rather than recounting valid bits, so it
  // stays a plain registered up/down counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else if (in_hs && !out_hs) begin
      occ_reg <= occ_reg + OCC_W'(1);
    end else if (out_hs && !in_hs) begin
      occ_reg <= occ_reg - OCC_W'(1);
    end
  end

  assign occupancy = occ_reg;

endmodule

// File: tb/tb_elastic_pipe.sv
module tb_elastic_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  int n_vec;
  int n_err;

  elastic_pipe #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         t;
  } word_t;

  vec_t  tbl [19];
  word_t q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [7:0] dat, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
  endtask

  // Apply the current inputs for one cycle and step to just after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Streaming with out_ready=1.
    tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd3};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd0};
    // Backpressure fill with 01..05, out_ready=0.
    tbl[7]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'hFF, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'hFF, 2'd2};
    tbl[10] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
    tbl[11] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
    // Release: simultaneous pop/push keeps occupancy at 3, then 77 enters full.
    tbl[12] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h01, 2'd3};
    tbl[13] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 2'd3};
    tbl[14] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h03, 2'd3};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2'd3};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 2'd2};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 2'd1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77, 2'd0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();

    // Table-driven directed vectors.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      check($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      next_cycle();
    end

    // Flush with occupancy=2 and a competing input word.
    drive(1'b0, 1'b1, 8'hF1, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 8'hF2, 1'b0); next_cycle();
    drive(1'b1, 1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_occ_before", 32'(occupancy), 32'd2);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("flush_occ_after", 32'(occupancy), 32'd0);
    check("flush_out_valid_after", 32'(out_valid), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    next_cycle();
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      check($sformatf("flush_drain%0d_out_valid", i), 32'(out_valid), 32'd0);
      next_cycle();
    end

    // Bubble collapse: words at stage 2 and stage 0, out_ready=0.
    drive(1'b0, 1'b1, 8'hB1, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 8'hB2, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("bub_in_ready", 32'(in_ready), 32'd1);
    check("bub_out_data", 32'(out_data), 32'hB1);
    check("bub_occupancy", 32'(occupancy), 32'd2);
    next_cycle();
    drive(1'b0, 1'b1, 8'hB3, 1'b0);
    @(negedge clk);
    check("bub_collapsed_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 8'hB4, 1'b0);
    @(negedge clk);
    check("bub_full_in_ready", 32'(in_ready), 32'd0);
    check("bub_full_occupancy", 32'(occupancy), 32'd3);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp_word;
      exp_word = 8'hB1 + 8'(i);
      @(negedge clk);
      check($sformatf("bub_drain%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bub_drain%0d_out_data", i), 32'(out_data), 32'(exp_word));
      next_cycle();
    end
    @(negedge clk);
    check("bub_empty_out_valid", 32'(out_valid), 32'd0);
    next_cycle();

    // Reset mid-stream with occupancy=2 and a word at the output.
    drive(1'b0, 1'b1, 8'h3C, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 8'hC3, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0); next_cycle();
    @(negedge clk);
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    check("prerst_out_data", 32'(out_data), 32'h3C);
    check("prerst_occupancy", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_occupancy", 32'(occupancy), 32'd0);
    next_cycle();

    // Randomized traffic against a queue-based reference model.
    // A word handshaken in cycle t reaches the output in cycle t+STAGES when
    // nothing is ahead of it; words behind it follow as the consumer frees
    // space, so the head of the queue is visible exactly when its age >= STAGES.
    q.delete();
    for (int c = 0; c < 800; c++) begin
      logic exp_ir;
      logic exp_ov;
      logic ohs;
      logic ihs;
      drive(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
            8'($urandom), ($urandom_range(0, 99) < 60));
      @(negedge clk);
      exp_ir = !flush && ((q.size() < STAGES) || out_ready);
      exp_ov = (q.size() > 0) && ((c - q[0].t) >= STAGES);
      check($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_ir));
      check($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(exp_ov));
      check($sformatf("rnd%0d_occupancy", c), 32'(occupancy), 32'(q.size()));
      if (exp_ov) begin
        check($sformatf("rnd%0d_out_data", c), 32'(out_data), 32'(q[0].d));
      end
      ohs = exp_ov && out_ready;
      ihs = in_valid && exp_ir;
      if (ohs) begin
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (ihs) begin
        q.push_back('{in_data, c});
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
